// File: rtl/packed_field_codec.sv
// Packs NFIELDS serial fields into one word, or unpacks a word into serial fields.
// Field 0 sits in the MSBs; a sticky ERROR flags a mode change in the middle of a word.
module packed_field_codec #(
  parameter int unsigned FIELD_W = 4,
  parameter int unsigned NFIELDS = 2,
  localparam int unsigned WORD_W = FIELD_W * NFIELDS,
  localparam int unsigned CNT_W  = $clog2(NFIELDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              ERROR
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(NFIELDS - 1);

  typedef enum logic [1:0] {StIdle, StFill, StEmit, StDrain} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               mode_q, mode_d;
  logic               error_q, error_d;
  logic [FIELD_W-1:0] field_sel;

  always_comb begin
    field_sel = '0;
    for (int unsigned i = 0; i < NFIELDS; i++) begin
      if (cnt_q == CNT_W'(i)) field_sel = word_q[WORD_W-1-i*FIELD_W -: FIELD_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    mode_d  = mode_q;
    error_d = error_q;
    if ((state_q != StIdle) && (mode != mode_q)) error_d = 1'b1;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          mode_d = mode;
          if (!mode) begin
            // Clearing the lower slots keeps stale data of an old word out of the new one
            word_d  = {in_data[FIELD_W-1:0], {(WORD_W-FIELD_W){1'b0}}};
            cnt_d   = CNT_W'(1);
            state_d = StFill;
          end else begin
            word_d  = in_data;
            cnt_d   = '0;
            state_d = StDrain;
          end
        end
      end
      StFill: begin
        if (in_valid) begin
          for (int unsigned i = 0; i < NFIELDS; i++) begin
            if (cnt_q == CNT_W'(i)) word_d[WORD_W-1-i*FIELD_W -: FIELD_W] = in_data[FIELD_W-1:0];
          end
          if (cnt_q == CntMax) begin
            cnt_d   = '0;
            state_d = StEmit;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StEmit: begin
        if (out_ready) state_d = StIdle;
      end
      StDrain: begin
        if (out_ready) begin
          if (cnt_q == CntMax) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      word_q  <= '0;
      mode_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      mode_q  <= mode_d;
      error_q <= error_d;
    end
  end

  // Outputs depend on registered state only, never on in_valid/out_ready
  always_comb begin
    in_ready  = (state_q == StIdle) || (state_q == StFill);
    out_valid = (state_q == StEmit) || (state_q == StDrain);
    out_data  = '0;
    out_last  = 1'b0;
    case (state_q)
      StEmit: begin
        out_data = word_q;
        out_last = 1'b1;
      end
      StDrain: begin
        out_data = {{(WORD_W-FIELD_W){1'b0}}, field_sel};
        out_last = (cnt_q == CntMax);
      end
      default: ;
    endcase
  end

  assign ERROR = error_q;

endmodule

// File: tb/tb_packed_field_codec.sv
// Directed bench for packed_field_codec: a 4x2 instance for table vectors and
// error/backpressure cases, an 8x4 instance for reset-abort and throughput.
module tb_packed_field_codec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: FIELD_W=4, NFIELDS=2
  logic       a_rst_n, a_mode, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_error;
  logic [7:0] a_in_data, a_out_data;

  packed_field_codec #(.FIELD_W(4), .NFIELDS(2)) u_a (
    .clk       (clk),
    .rst_n     (a_rst_n),
    .mode      (a_mode),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_last  (a_out_last),
    .ERROR     (a_error)
  );

  // Instance B: FIELD_W=8, NFIELDS=4
  logic        b_rst_n, b_mode, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_error;
  logic [31:0] b_in_data, b_out_data;

  packed_field_codec #(.FIELD_W(8), .NFIELDS(4)) u_b (
    .clk       (clk),
    .rst_n     (b_rst_n),
    .mode      (b_mode),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_last  (b_out_last),
    .ERROR     (b_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       mode;
    logic [7:0] a;     // pack: field 0; unpack: word
    logic [7:0] b;     // pack: field 1; unpack: unused
    logic [7:0] exp0;  // pack: word; unpack: first field beat
    logic [7:0] exp1;  // unpack: second field beat
  } vec_t;

  vec_t vecs[6];

  // Pack two fields on A and check the emitted word, its latency and return to idle.
  task automatic a_pack(input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] exp);
    a_mode = 1'b0; a_in_valid = 1'b1; a_in_data = f0; a_out_ready = 1'b0;
    @(negedge clk);
    chk("pack_mid_valid", 32'(a_out_valid), 32'd0);
    a_in_data = f1;
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("pack_valid", 32'(a_out_valid), 32'd1);
    chk("pack_data", 32'(a_out_data), 32'(exp));
    chk("pack_last", 32'(a_out_last), 32'd1);
    chk("pack_in_ready", 32'(a_in_ready), 32'd0);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    chk("pack_idle_valid", 32'(a_out_valid), 32'd0);
    chk("pack_idle_ready", 32'(a_in_ready), 32'd1);
  endtask

  task automatic a_unpack(input logic [7:0] w, input logic [7:0] e0, input logic [7:0] e1);
    a_mode = 1'b1; a_in_valid = 1'b1; a_in_data = w; a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("unpack_b0_valid", 32'(a_out_valid), 32'd1);
    chk("unpack_b0_data", 32'(a_out_data), 32'(e0));
    chk("unpack_b0_last", 32'(a_out_last), 32'd0);
    chk("unpack_b0_ready", 32'(a_in_ready), 32'd0);
    @(negedge clk);
    chk("unpack_b1_data", 32'(a_out_data), 32'(e1));
    chk("unpack_b1_last", 32'(a_out_last), 32'd1);
    chk("unpack_b1_ready", 32'(a_in_ready), 32'd0);
    @(negedge clk);
    a_out_ready = 1'b0;
    chk("unpack_idle_valid", 32'(a_out_valid), 32'd0);
    chk("unpack_idle_ready", 32'(a_in_ready), 32'd1);
  endtask

  task automatic b_send_field(input logic [7:0] f);
    b_in_valid = 1'b1; b_in_data = {24'h0, f};
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0]  tf[16];
    logic [31:0] exp_w;
    int          k, beats, last_cyc;

    vecs[0] = '{1'b0, 8'h05, 8'h0a, 8'h5a, 8'h00};
    vecs[1] = '{1'b0, 8'h0f, 8'h00, 8'hf0, 8'h00};
    vecs[2] = '{1'b0, 8'h13, 8'h2c, 8'h3c, 8'h00};  // upper nibbles ignored
    vecs[3] = '{1'b1, 8'h5a, 8'h00, 8'h05, 8'h0a};
    vecs[4] = '{1'b1, 8'hff, 8'h00, 8'h0f, 8'h0f};
    vecs[5] = '{1'b1, 8'h81, 8'h00, 8'h08, 8'h01};

    a_rst_n = 1'b0; a_mode = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_rst_n = 1'b0; b_mode = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_out_last", 32'(a_out_last), 32'd0);
    chk("rst_error", 32'(a_error), 32'd0);
    @(negedge clk);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].mode) a_unpack(vecs[i].a, vecs[i].exp0, vecs[i].exp1);
      else              a_pack(vecs[i].a, vecs[i].b, vecs[i].exp0);
    end
    chk("table_error", 32'(a_error), 32'd0);

    // Backpressure: first field held for 5 stalled cycles, then each field exactly once
    a_mode = 1'b1; a_in_valid = 1'b1; a_in_data = 8'h3c; a_out_ready = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(a_out_valid), 32'd1);
      chk("bp_hold_data", 32'(a_out_data), 32'h03);
      chk("bp_hold_last", 32'(a_out_last), 32'd0);
      @(negedge clk);
    end
    a_out_ready = 1'b1;
    chk("bp_beat0", 32'(a_out_data), 32'h03);
    @(negedge clk);
    chk("bp_beat1", 32'(a_out_data), 32'h0c);
    chk("bp_beat1_last", 32'(a_out_last), 32'd1);
    @(negedge clk);
    chk("bp_done_valid", 32'(a_out_valid), 32'd0);
    a_out_ready = 1'b0;

    // Mode violation mid-pack: word still assembled, ERROR sticks until reset
    a_mode = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h05;
    @(negedge clk);
    chk("mv_pre_error", 32'(a_error), 32'd0);
    a_mode = 1'b1; a_in_data = 8'h0a;
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("mv_valid", 32'(a_out_valid), 32'd1);
    chk("mv_data", 32'(a_out_data), 32'h5a);
    chk("mv_error", 32'(a_error), 32'd1);
    a_mode = 1'b0; a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("mv_error_sticky", 32'(a_error), 32'd1);
    a_rst_n = 1'b0;
    #1;
    chk("mv_error_cleared", 32'(a_error), 32'd0);
    @(negedge clk);
    a_rst_n = 1'b1;

    // Reset mid-word on the 8x4 instance discards the partial word
    b_mode = 1'b0; b_out_ready = 1'b1;
    b_send_field(8'h11);
    b_send_field(8'h22);
    b_rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(b_in_ready), 32'd1);
    chk("midrst_out_valid", 32'(b_out_valid), 32'd0);
    chk("midrst_out_data", b_out_data, 32'd0);
    chk("midrst_out_last", 32'(b_out_last), 32'd0);
    @(negedge clk);
    b_rst_n = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    b_send_field(8'h11);
    b_send_field(8'h22);
    b_send_field(8'h33);
    chk("midrst_no_early", 32'(b_out_valid), 32'd0);
    b_send_field(8'h44);
    chk("midrst_valid", 32'(b_out_valid), 32'd1);
    chk("midrst_word", b_out_data, 32'h11223344);
    b_out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_done", 32'(b_out_valid), 32'd0);

    // Throughput: 4 back-to-back words with both sides always willing
    for (int i = 0; i < 16; i++) tf[i] = 8'(8'h11 * (i + 1));
    k = 0; beats = 0; last_cyc = -1;
    b_out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (b_out_valid) begin
        if (beats < 4) begin
          exp_w = {tf[4*beats], tf[4*beats+1], tf[4*beats+2], tf[4*beats+3]};
          chk("tput_word", b_out_data, exp_w);
        end
        if (last_cyc >= 0) chk("tput_period", 32'(cyc - last_cyc), 32'd5);
        last_cyc = cyc;
        beats++;
      end
      if (k < 16) begin
        b_in_valid = 1'b1;
        b_in_data  = {24'h0, tf[k]};
        if (b_in_ready) k++;
      end else begin
        b_in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("tput_beats", 32'(beats), 32'd4);
    chk("tput_error", 32'(b_error), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/packed_field_codec.md
# packed_field_codec

Parametrised packer/unpacker for packed-struct-style words built from `NFIELDS` equal fields of `FIELD_W` bits each. Field 0 is the first-declared member and occupies the MSBs, so a two-nibble word 8'h5a has field 0 = 4'h5 and field 1 = 4'ha. In pack mode the block gathers fields one per handshake into a word. In unpack mode it splits a word into fields. It sits between field-serial producers and consumers and the word-wide datapath, with valid/ready flow control on both sides and a sticky `ERROR` self-check flag.

## Interface
- `FIELD_W`, 4, bits per field (>=1).
- `NFIELDS`, 2, fields per word (>=2).
- Derived: `WORD_W = FIELD_W*NFIELDS`; counter width `CNT_W = $clog2(NFIELDS)`.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `mode`  input  1  0 = pack, 1 = unpack; sampled only on a word's first accepted input beat.
- `in_valid`  input  1  input beat valid.
- `in_ready`  output  1  block accepts the input beat.
- `in_data`  input  WORD_W  pack: field in `[FIELD_W-1:0]`, upper bits ignored; unpack: whole word.
- `out_valid`  output  1  output beat valid.
- `out_ready`  input  1  consumer accepts the output beat.
- `out_data`  output  WORD_W  pack: whole word; unpack: field in `[FIELD_W-1:0]`, upper bits 0.
- `out_last`  output  1  final beat of a word (always 1 in pack mode).
- `ERROR`  output  1  sticky protocol-error flag.

## Operation
- Handshake: a beat transfers on a cycle with valid & ready high at the rising `clk` edge.
- Once a source raises valid, it holds valid and data until the transfer; the block does the same on the output side.
- States:
  - IDLE: `in_ready=1`, `out_valid=0`. The first input transfer latches `mode` into `mode_q`.
    - Pack: store the field at field 0 (MSBs), set `cnt=1`, go to FILL.
    - Unpack: store the word, set `cnt=0`, go to DRAIN.
  - FILL (pack): `in_ready=1`. Each transfer writes `in_data[FIELD_W-1:0]` into field slot `cnt`, i.e. bits `[WORD_W-1-cnt*FIELD_W -: FIELD_W]`, then `cnt++`. The transfer with `cnt==NFIELDS-1` goes to EMIT.
  - EMIT (pack): `in_ready=0`, `out_valid=1`, `out_data` = assembled word, `out_last=1`. An output transfer goes to IDLE.
  - DRAIN (unpack): `in_ready=0`, `out_valid=1`, `out_data` = {0, field `cnt`}, `out_last=(cnt==NFIELDS-1)`. Each output transfer does `cnt++`. The transfer with `out_last` goes to IDLE.
- `mode_q` holds for the whole word. If `mode != mode_q` on any cycle outside IDLE, `ERROR` is set to 1 and operation continues with `mode_q`.
- `ERROR` clears only on reset.
- Field order is fixed: first in / first out = MSB field, in both modes.
- Storage is a single WORD_W register, with no buffering beyond one word. A new word is never accepted while the previous word is still draining.

## Timing
- Reset (async assert, deassertion synchronised by the integrator): state IDLE, `cnt=0`, word register 0, `mode_q=0`, `in_ready=1`, `out_valid=0`, `out_data=0`, `out_last=0`, `ERROR=0`.
- Asserting reset mid-word discards the partial word immediately; no output beat is produced for it.
- Pack latency: `out_valid` rises on the cycle after the NFIELDS-th input transfer. The minimum word period is NFIELDS+1 cycles.
- Unpack latency: field 0 appears on the cycle after the word transfer. With `out_ready` held high, one field is emitted per cycle. `in_ready` returns on the cycle after the `out_last` transfer, giving a minimum period of NFIELDS+1 cycles.
- Backpressure: with `out_ready=0`, `out_valid`, `out_data` and `out_last` are held stable indefinitely.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- `cnt` wraps to 0 on every return to IDLE and never exceeds NFIELDS-1.

## Test plan
- Defaults, pack: mode=0, send 4'h5 then 4'ha -> one beat `out_data=8'h5a`, `out_last=1`, one cycle after the second transfer; `ERROR=0`.
- Defaults, unpack: mode=1, send 8'h5a -> beats 8'h05 (`out_last=0`) then 8'h0a (`out_last=1`) on consecutive cycles; `in_ready=0` throughout, and 1 on the following cycle.
- Backpressure: unpack 8'h3c with `out_ready=0` for 5 cycles -> `out_data=8'h03` held stable for all 5 cycles, then 8'h03 and 8'h0c delivered once each with no loss or duplication.
- Mode violation: pack mode, send field 4'h5, toggle mode to 1, send 4'ha -> word 8'h5a still emitted; `ERROR=1` and stays 1 until `rst_n` is pulsed low.
- Reset mid-operation: FIELD_W=8, NFIELDS=4, send 8'h11 and 8'h22, pulse `rst_n` low -> all outputs at reset values. Then send 8'h11, 8'h22, 8'h33, 8'h44 -> `out_data=32'h11223344`.
- Throughput: NFIELDS=4, FIELD_W=8, with `in_valid` and `out_ready` held high over back-to-back packs of 4 words -> exactly 4 output beats at a 5-cycle period, each word correct.
